pid_pwm: RTL and testbench

- Downstream stage of the PID controller. Accepts the controller's signed command sample, clamps it to a duty count and drives a centre-less, edge-aligned PWM output for the actuator power stage.
- Uses a single-entry shadow register with valid/ready handshake. New duty and period take effect only at a period boundary, so there are no runt pulses.

---
 rtl/pid_pkg.sv | 40 ++++
 rtl/pid_pwm_if.sv | 11 +
 rtl/pid_deadtime.sv | 51 +++++
 rtl/pid_pwm.sv | 142 ++++++++++++++
 tb/tb_pid_pwm.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
// Shared types for the PWM output stage of the PID controller: FSM state,
// default widths and the command clamp.
package pid_pkg;

    localparam int CMD_W_DEF = 16;
    localparam int CNT_W_DEF = 12;
    localparam int DT_W_DEF  = 6;

    // Clamp compare width; must cover max(CMD_W, CNT_W+2) so both operands stay exact.
    localparam int CLAMP_W = 32;

    typedef enum logic [1:0] {
        PWM_IDLE,
        PWM_RUN,
        PWM_DRAIN
    } pwm_state_e;

    typedef struct packed {
        logic [CLAMP_W-1:0] duty;
        logic               sat_hi;
        logic               sat_lo;
    } clamp_t;

    function automatic clamp_t clamp_cmd(input logic signed [CLAMP_W-1:0] cmd,
                                         input logic signed [CLAMP_W-1:0] limit);
        clamp_t r;
        r.duty   = cmd;
        r.sat_hi = 1'b0;
        r.sat_lo = 1'b0;
        if (cmd < 0) begin
            r.duty   = '0;
            r.sat_lo = 1'b1;
        end else if (cmd > limit) begin
            r.duty   = limit;
            r.sat_hi = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pid_pwm_if.sv
// Command handshake from the PID controller into the PWM stage.
interface pid_pwm_if #(
    parameter int CMD_W = pid_pkg::CMD_W_DEF
) ();
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;

    modport master(output cmd, output cmd_valid, input cmd_ready);
    modport slave(input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/pid_deadtime.sv
// Complementary output pair with dead-time blanking on every raw PWM edge.
// Built only when PID_PWM_DEADTIME_EN is defined.
module pid_deadtime
    import pid_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            active,
    input  logic            pwm_raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_out,
    output logic            pwm_out_n
);

    logic            raw_prev_q;
    logic [DT_W-1:0] dt_q, dt_d;
    logic            raw_edge;
    logic            blank;

    assign raw_edge = pwm_raw ^ raw_prev_q;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        blank = 1'b0;
        dt_d  = dt_q;
        if (raw_edge) begin
            // The edge cycle itself is the first blanked cycle; a new edge restarts the count.
            blank = (dead_time != '0);
            dt_d  = (dead_time != '0) ? dead_time - 1'b1 : '0;
        end else if (dt_q != '0) begin
            blank = 1'b1;
            dt_d  = dt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_prev_q <= 1'b0;
            dt_q       <= '0;
        end else begin
            raw_prev_q <= pwm_raw;
            dt_q       <= dt_d;
        end
    end

    assign pwm_out   = active & ~blank & pwm_raw;
    assign pwm_out_n = active & ~blank & ~pwm_raw;

endmodule

// File: rtl/pid_pwm.sv
// Edge-aligned PWM stage: clamps PID commands into a shadow duty register and
// applies duty/period only at period boundaries. Dead-time via PID_PWM_DEADTIME_EN.
module pid_pwm
    import pid_pkg::*;
#(
    parameter int CMD_W = CMD_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [DT_W-1:0]  dead_time,
    pid_pwm_if.slave         cmd_if,
    output logic             pwm_out,
    output logic             pwm_out_n,
    output logic             period_start,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic [CNT_W:0]   duty_act
);

    pwm_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_act_q;
    logic [CNT_W:0]       duty_act_q;
    logic [CNT_W:0]       shadow_q;
    logic                 shadow_full_q;
    logic                 sat_hi_q, sat_lo_q;
    logic                 pwm_raw_q, pwm_raw_d;
    logic                 start_q, start_d;
    logic                 at_end, boundary, accept, active;
    logic [CNT_W:0]       limit;
    logic signed [CLAMP_W-1:0] cmd_ext, limit_ext;
    clamp_t               clamp_res;

    assign at_end = (cnt_q == period_act_q);
    assign active = (state_q != PWM_IDLE);
    assign accept = cmd_if.cmd_valid & ~shadow_full_q;

    assign limit     = {1'b0, period} + 1'b1;
    assign cmd_ext   = {{(CLAMP_W-CMD_W){cmd_if.cmd[CMD_W-1]}}, cmd_if.cmd};
    assign limit_ext = {{(CLAMP_W-CNT_W-1){1'b0}}, limit};
    assign clamp_res = clamp_cmd(cmd_ext, limit_ext);

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PWM_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PWM_IDLE:  if (en) state_d = PWM_RUN;
            PWM_RUN:   if (!en) state_d = at_end ? PWM_IDLE : PWM_DRAIN;
            PWM_DRAIN: begin
                if (en)          state_d = PWM_RUN;
                else if (at_end) state_d = PWM_IDLE;
            end
            default:   state_d = PWM_IDLE;
        endcase
    end

    always_comb begin
        boundary  = 1'b0;
        cnt_d     = '0;
        pwm_raw_d = 1'b0;
        start_d   = 1'b0;
        unique case (state_q)
            PWM_IDLE: boundary = en;
            PWM_RUN, PWM_DRAIN: begin
                boundary  = (state_q == PWM_RUN) && at_end;
                cnt_d     = at_end ? '0 : cnt_q + 1'b1;
                pwm_raw_d = ({1'b0, cnt_q} < duty_act_q);
                start_d   = (state_q == PWM_RUN) && (cnt_q == '0);
            end
            default: ;
        endcase
    end

    // NOTE: the shadow is an ordinary register, so it is reset too; a reset must discard a pending duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            period_act_q  <= '0;
            duty_act_q    <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            sat_hi_q      <= 1'b0;
            sat_lo_q      <= 1'b0;
            pwm_raw_q     <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pwm_raw_q <= pwm_raw_d;
            start_q   <= start_d;
            if (boundary) begin
                period_act_q <= period;
                if (shadow_full_q) duty_act_q <= shadow_q;
            end
            // Load and accept never coincide: accept requires an empty shadow.
            if (boundary && shadow_full_q) begin
                shadow_full_q <= 1'b0;
            end else if (accept) begin
                shadow_q      <= clamp_res.duty[CNT_W:0];
                shadow_full_q <= 1'b1;
                sat_hi_q      <= clamp_res.sat_hi;
                sat_lo_q      <= clamp_res.sat_lo;
            end
        end
    end

    assign cmd_if.cmd_ready = ~shadow_full_q;
    assign period_start     = start_q;
    assign sat_hi           = sat_hi_q;
    assign sat_lo           = sat_lo_q;
    assign duty_act         = duty_act_q;

`ifdef PID_PWM_DEADTIME_EN
    logic unused_bits;
    assign unused_bits = ^clamp_res.duty[CLAMP_W-1:CNT_W+1];

    pid_deadtime #(.DT_W(DT_W)) u_deadtime (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (active),
        .pwm_raw  (pwm_raw_q & active),
        .dead_time(dead_time),
        .pwm_out  (pwm_out),
        .pwm_out_n(pwm_out_n)
    );
`else
    logic unused_bits;
    assign unused_bits = ^{dead_time, clamp_res.duty[CLAMP_W-1:CNT_W+1]};

    assign pwm_out   = active & pwm_raw_q;
    assign pwm_out_n = active & ~pwm_raw_q;
`endif

endmodule

// File: tb/tb_pid_pwm.sv
// Directed bench for pid_pwm: handshake, clamp, boundary loads, drain, reset,
// and dead-time insertion when PID_PWM_DEADTIME_EN is defined.
module tb_pid_pwm;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] period;
    logic [5:0]  dead_time;
    logic        pwm_out, pwm_out_n, period_start, sat_hi, sat_lo;
    logic [12:0] duty_act;

    int errs, checks;
    int ph, prev_ph, per_m;
    bit run_m;

    pid_pwm_if #(.CMD_W(16)) bus ();

    pid_pwm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period      (period),
        .dead_time   (dead_time),
        .cmd_if      (bus),
        .pwm_out     (pwm_out),
        .pwm_out_n   (pwm_out_n),
        .period_start(period_start),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .duty_act    (duty_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; ph is the counter value the DUT should now hold.
    task automatic tick();
        @(posedge clk);
        #1;
        prev_ph = ph;
        if (run_m) ph = (ph >= per_m) ? 0 : ph + 1;
    endtask

    task automatic accept(input logic [15:0] v);
        bus.cmd       = v;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic to_wrap();
        tick();
        while (ph != 0) tick();
    endtask

`ifdef PID_PWM_DEADTIME_EN
    logic exp_o  [13] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic exp_on [13] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
`endif

    initial begin
        errs = 0; checks = 0; ph = 0; prev_ph = 0; per_m = 9; run_m = 0;
        rst_n = 1'b0; en = 1'b0; period = 12'd9; dead_time = '0;
        bus.cmd = '0; bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_pwm_out_n", pwm_out_n, 0);
        check("rst_period_start", period_start, 0);
        check("rst_sat_hi", sat_hi, 0);
        check("rst_sat_lo", sat_lo, 0);
        check("rst_duty_act", duty_act, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        rst_n = 1'b1;

        // Basic run: duty 4 of period 10.
        accept(16'd4);
        check("t1_ready_full", bus.cmd_ready, 0);
        check("t1_duty_before_en", duty_act, 0);
        en = 1'b1;
        tick();
        run_m = 1;
        check("t1_duty_loaded", duty_act, 4);
        check("t1_ready_after_load", bus.cmd_ready, 1);
        check("t1_first_cycle_low", pwm_out, 0);
        check("t1_first_cycle_n", pwm_out_n, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_pwm", pwm_out, prev_ph < 4);
            check("t1_pwm_n", pwm_out_n, !(prev_ph < 4));
            check("t1_period_start", period_start, prev_ph == 0);
        end

        // Negative command clamps to zero duty.
        accept(16'hFFFB);
        check("t2_sat_lo", sat_lo, 1);
        check("t2_sat_hi_clear", sat_hi, 0);
        check("t2_duty_held", duty_act, 4);
        to_wrap();
        check("t2_duty_zero", duty_act, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_const_low", pwm_out, 0);
        end

        // Oversized command clamps to period+1: constant high across the wrap.
        accept(16'd50);
        check("t2_sat_hi", sat_hi, 1);
        check("t2_sat_lo_clear", sat_lo, 0);
        to_wrap();
        check("t2_duty_full", duty_act, 10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t2_const_high", pwm_out, 1);
            check("t2_const_high_n", pwm_out_n, 0);
        end

        // Mid-period accept waits for the boundary.
        accept(16'd7);
        to_wrap();
        check("t3_duty7", duty_act, 7);
        while (ph != 3) tick();
        accept(16'd3);
        check("t3_pwm_at_accept", pwm_out, 1);
        check("t3_ready_low", bus.cmd_ready, 0);
        while (ph != 0) begin
            tick();
            check("t3_old_duty_pwm", pwm_out, prev_ph < 7);
            check("t3_ready", bus.cmd_ready, ph == 0);
            check("t3_duty_act", duty_act, (ph == 0) ? 3 : 7);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_new_duty_pwm", pwm_out, prev_ph < 3);
        end

        // Drop en at cnt=5: drain to the end of the period, then idle.
        while (ph != 5) tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_drain_n", pwm_out_n, 1);
            check("t4_drain_start", period_start, 0);
        end
        tick();
        run_m = 0;
        check("t4_idle_out", pwm_out, 0);
        check("t4_idle_out_n", pwm_out_n, 0);
        tick();
        check("t4_idle_out_n2", pwm_out_n, 0);
        check("t4_idle_duty", duty_act, 3);
        en = 1'b1;
        tick();
        run_m = 1;
        check("t4_rerun_n", pwm_out_n, 1);
        // Re-raise en during drain: counting continues, no restart.
        while (ph != 5) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_no_restart_start", period_start, prev_ph == 0);
        end

        // period=0: one-cycle period, duty clamps to 1, constant high.
        period = 12'd0;
        accept(16'd5);
        check("p0_sat_hi", sat_hi, 1);
        to_wrap();
        per_m = 0;
        check("p0_duty", duty_act, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p0_pwm", pwm_out, 1);
            check("p0_start", period_start, 1);
        end

        // Asynchronous reset mid-period with the shadow full.
        period = 12'd9;
        accept(16'd2);
        check("t5_ready_full", bus.cmd_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_pwm", pwm_out, 0);
        check("t5_rst_pwm_n", pwm_out_n, 0);
        check("t5_rst_start", period_start, 0);
        check("t5_rst_ready", bus.cmd_ready, 1);
        check("t5_rst_duty", duty_act, 0);
        check("t5_rst_sat_hi", sat_hi, 0);
        en = 1'b0;
        run_m = 0; ph = 0; per_m = 9;
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        run_m = 1;
        check("t5_duty_discarded", duty_act, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_low_after_rst", pwm_out, 0);
        end

`ifdef PID_PWM_DEADTIME_EN
        // Dead-time of 2 cycles at each raw edge, then exact complements with 0.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        en = 1'b0;
        dead_time = 6'd2;
        run_m = 0; ph = 0;
        tick();
        accept(16'd4);
        en = 1'b1;
        tick();
        run_m = 1;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            check("dt_out", pwm_out, exp_o[i]);
            check("dt_out_n", pwm_out_n, exp_on[i]);
            check("dt_overlap", pwm_out & pwm_out_n, 0);
        end
        dead_time = 6'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("dt0_out", pwm_out, prev_ph < 4);
            check("dt0_out_n", pwm_out_n, !(prev_ph < 4));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
